// File: rtl/fsm_in_pkg.sv
// Shared constants, the commit-decision type and the counter-width helper
// for the i1/i2 input conditioner.
package fsm_in_pkg;

    localparam int DB_CYCLES_DEF   = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SKEW_MAX_DEF    = 4;

    // Width of the skew wait counter; covers SKEW_MAX up to 15.
    localparam int WCNT_W = 4;

    // Which channels take their synchronised level on this edge.
    typedef struct packed {
        logic c1;
        logic c2;
    } commit_t;

    // Debounce counter width: ceil(log2(n)), never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsm_in_cond_if.sv
// Raw inputs and conditioned outputs of the input conditioner.
interface fsm_in_cond_if;
    import fsm_in_pkg::*;

    logic raw1;
    logic raw2;
    logic i1;
    logic i2;
    logic chg;
    logic stable;

    modport master (output raw1, output raw2,
                    input i1, input i2, input chg, input stable);
    modport slave  (input raw1, input raw2,
                    output i1, output i2, output chg, output stable);
endinterface

// File: rtl/fsm_in_db_chan.sv
// One input channel: synchroniser chain plus debounce counter. Flags READY
// when the synchronised level has disagreed with the committed level long
// enough, PENDING while a disagreement is still being counted.
module fsm_in_db_chan
    import fsm_in_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    input  logic level,
    input  logic commit,
    output logic s,
    output logic ready,
    output logic pending,
    output logic cnt_zero_nxt
);
    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    assign s       = sync[SYNC_STAGES-1];
    assign ready   = (s != level) && (cnt == CNT_MAX);
    assign pending = (cnt != '0) && !ready;

    // Count consecutive mismatches; any agreement or a commit restarts it,
    // and a full count holds until the top level commits.
    always_comb begin
        cnt_nxt = cnt;
        if (s == level || commit) cnt_nxt = '0;
        else if (cnt != CNT_MAX)  cnt_nxt = cnt + 1'b1;
    end

    assign cnt_zero_nxt = (cnt_nxt == '0);

    // Debounce counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt <= '0;
        else       cnt <= cnt_nxt;
    end
endmodule

// File: rtl/fsm_in_cond.sv
// Input conditioner ahead of the i1/i2 control FSM. Debounces both raw
// lines and lines up near-simultaneous changes so the FSM never sees a
// transient one-channel-only combination caused by skew.
module fsm_in_cond
    import fsm_in_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int SKEW_MAX    = SKEW_MAX_DEF
) (
    input  logic          clk,
    input  logic          nrst,
    fsm_in_cond_if.slave  bus
);
    localparam logic [WCNT_W-1:0] SKEW_LIM = WCNT_W'(SKEW_MAX);

    logic s1, s2;
    logic ready1, ready2;
    logic pend1, pend2;
    logic zero1, zero2;
    logic i1_q, i2_q, chg_q, stable_q;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    commit_t act;

    fsm_in_db_chan #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_ch1 (
        .clk          (clk),
        .nrst         (nrst),
        .raw          (bus.raw1),
        .level        (i1_q),
        .commit       (act.c1),
        .s            (s1),
        .ready        (ready1),
        .pending      (pend1),
        .cnt_zero_nxt (zero1)
    );

    fsm_in_db_chan #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_ch2 (
        .clk          (clk),
        .nrst         (nrst),
        .raw          (bus.raw2),
        .level        (i2_q),
        .commit       (act.c2),
        .s            (s2),
        .ready        (ready2),
        .pending      (pend2),
        .cnt_zero_nxt (zero2)
    );

    // Decide which channels commit this edge; a lone ready channel waits up
    // to SKEW_MAX extra cycles while its partner is still counting.
    always_comb begin
        act      = '0;
        wcnt_nxt = '0;
        if (ready1 && ready2) begin
            act.c1 = 1'b1;
            act.c2 = 1'b1;
        end else if (ready1 || ready2) begin
            if ((ready1 ? pend2 : pend1) && (wcnt < SKEW_LIM)) begin
                wcnt_nxt = wcnt + 1'b1;
            end else begin
                act.c1 = ready1;
                act.c2 = ready2;
            end
        end
    end

    // Conditioned levels, change pulse, stability flag and skew counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i1_q     <= 1'b0;
            i2_q     <= 1'b0;
            chg_q    <= 1'b0;
            stable_q <= 1'b1;
            wcnt     <= '0;
        end else begin
            if (act.c1) i1_q <= s1;
            if (act.c2) i2_q <= s2;
            chg_q    <= act.c1 | act.c2;
            stable_q <= zero1 && zero2 && (wcnt_nxt == '0);
            wcnt     <= wcnt_nxt;
        end
    end

    assign bus.i1     = i1_q;
    assign bus.i2     = i2_q;
    assign bus.chg    = chg_q;
    assign bus.stable = stable_q;
endmodule

// File: tb/tb_fsm_in_cond.sv
// Directed bench for fsm_in_cond with default parameters. Stimulus pushes
// the expected (i1, i2, commit edge) for every commit it provokes; a monitor
// pops and compares each time chg is seen.
module tb_fsm_in_cond;
    import fsm_in_pkg::*;

    typedef struct {
        logic i1;
        logic i2;
        int   cyc;
    } exp_t;

    logic clk;
    logic nrst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    logic chk_skew;
    exp_t exp_q[$];

    fsm_in_cond_if bus ();

    fsm_in_cond dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_chk = n_chk + 1;
        if (act != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic e1, input logic e2, input int c);
        exp_t e;
        e.i1  = e1;
        e.i2  = e2;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every chg pulse must match the next expected commit.
    always @(negedge clk) begin
        if (nrst && bus.chg) begin
            if (exp_q.size() == 0) begin
                check("unexpected_chg", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_cycle", cyc, e.cyc);
                check("commit_i1", int'(bus.i1), int'(e.i1));
                check("commit_i2", int'(bus.i2), int'(e.i2));
            end
        end
        if (nrst && chk_skew)
            check("no_i1_only", int'(bus.i1 && !bus.i2), 0);
    end

    initial begin
        int t;
        cyc      = 0;
        n_chk    = 0;
        n_fail   = 0;
        chk_skew = 1'b0;
        nrst     = 1'b0;
        bus.raw1 = 1'b1;
        bus.raw2 = 1'b1;

        // Reset with both raw lines high, then release.
        step(3);
        check("rst_i1", int'(bus.i1), 0);
        check("rst_i2", int'(bus.i2), 0);
        check("rst_chg", int'(bus.chg), 0);
        check("rst_stable", int'(bus.stable), 1);
        nrst = 1'b1;
        t = cyc;
        push(1'b1, 1'b1, t + 10);
        step(9);
        check("rst_rel_i1_e9", int'(bus.i1), 0);
        step(1);
        check("rst_rel_i1_e10", int'(bus.i1), 1);
        step(4);

        // Both fall together: single joint commit.
        bus.raw1 = 1'b0;
        bus.raw2 = 1'b0;
        push(1'b0, 1'b0, cyc + 10);
        step(14);

        // Clean single change on channel 1 with stable tracking.
        bus.raw1 = 1'b1;
        t = cyc;
        push(1'b1, 1'b0, t + 10);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check("stable_single", int'(bus.stable), int'(k < 3 || k >= 10));
        end
        check("single_i2", int'(bus.i2), 0);
        bus.raw1 = 1'b0;
        push(1'b0, 1'b0, cyc + 10);
        step(14);

        // Bounce: 5 cycles high, 2 low, then steady high.
        bus.raw1 = 1'b1;
        step(5);
        bus.raw1 = 1'b0;
        step(2);
        bus.raw1 = 1'b1;
        t = cyc;
        push(1'b1, 1'b0, t + 10);
        step(9);
        check("bounce_i1_early", int'(bus.i1), 0);
        step(5);
        bus.raw1 = 1'b0;
        push(1'b0, 1'b0, cyc + 10);
        step(14);

        // Skew within SKEW_MAX: joint rise 13 edges after raw1.
        chk_skew = 1'b1;
        bus.raw1 = 1'b1;
        t = cyc;
        step(3);
        bus.raw2 = 1'b1;
        push(1'b1, 1'b1, t + 13);
        step(14);
        chk_skew = 1'b0;
        bus.raw1 = 1'b0;
        bus.raw2 = 1'b0;
        push(1'b0, 1'b0, cyc + 10);
        step(14);

        // Skew beyond SKEW_MAX: i1 alone at 14, i2 at 16.
        bus.raw1 = 1'b1;
        t = cyc;
        step(6);
        bus.raw2 = 1'b1;
        push(1'b1, 1'b0, t + 14);
        push(1'b1, 1'b1, t + 16);
        step(14);
        bus.raw1 = 1'b0;
        bus.raw2 = 1'b0;
        push(1'b0, 1'b0, cyc + 10);
        step(14);

        // Reset mid-debounce: pending change discarded, restarts on release.
        bus.raw1 = 1'b1;
        step(6);
        nrst = 1'b0;
        #1;
        check("mid_rst_i1", int'(bus.i1), 0);
        check("mid_rst_stable", int'(bus.stable), 1);
        step(2);
        nrst = 1'b1;
        t = cyc;
        push(1'b1, 1'b0, t + 10);
        step(9);
        check("mid_rst_i1_e9", int'(bus.i1), 0);
        step(5);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsm_in_cond.md
Name: fsm_in_cond

Overview:
- Input conditioner directly upstream of the i1/i2 control FSM.
- Takes two raw, asynchronous, possibly bouncing control lines, synchronises and debounces each one, and presents clean level signals i1/i2.
- Aligns near-simultaneous changes on the two channels so the downstream FSM never sees a transient one-channel-only combination (e.g. i1=1,i2=0 → spurious ERROR) caused by skew.
- Also emits change/stability status for monitoring.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per channel (legal 2..4).
- DB_CYCLES, 8, consecutive mismatch cycles needed to accept a new level (legal 2..255).
- SKEW_MAX, 4, max extra cycles a ready channel waits for a pending partner (legal 0..15; 0 disables alignment).

Ports:
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- raw1  input  1  raw asynchronous channel 1
- raw2  input  1  raw asynchronous channel 2
- i1  output  1  conditioned channel 1, registered
- i2  output  1  conditioned channel 2, registered
- chg  output  1  one-cycle pulse on any edge where i1 or i2 updates
- stable  output  1  high when both channels have cnt==0 and no wait is pending

Behaviour:
- Reset (nrst=0, asynchronous):
  - All sync flops, i1, i2, chg, debounce counters and skew counter → 0.
  - stable → 1.
  - Reset mid-debounce discards pending changes; no chg pulse is produced on reset release.
- Synchroniser: raw_n passes through SYNC_STAGES flops. Output s_n is the only signal used downstream; raw_n is never sampled directly.
- Per-channel debounce, width ceil(log2(DB_CYCLES)):
  - s_n == i_n: cnt_n ← 0, channel idle.
  - s_n != i_n and cnt_n < DB_CYCLES-1: cnt_n ← cnt_n+1.
  - s_n != i_n and cnt_n == DB_CYCLES-1: channel READY (counter holds).
  - Any bounce back (s_n == i_n) before commit clears cnt_n; the count restarts from 0 on the next mismatch.
- Commit / alignment:
  - Single skew counter wcnt.
  - PENDING(n) = cnt_n != 0 and not READY.
  - Both READY on the same edge: commit both (i1 ← s1, i2 ← s2), clear both counters and wcnt, chg=1.
  - One READY, other not PENDING: commit the ready one alone, chg=1.
  - One READY, other PENDING, wcnt < SKEW_MAX: hold, wcnt ← wcnt+1. The other channel may become READY during the wait, leading to a joint commit.
  - wcnt == SKEW_MAX with partner still not READY: commit the ready channel alone, wcnt ← 0.
  - Ready channel bounces back during the wait: its cnt clears, wcnt ← 0, no commit.
- Latency: raw held steady, other channel idle → i_n updates on the (SYNC_STAGES+DB_CYCLES)th rising edge after the raw change (10 with defaults); chg is high in the cycle following that edge.
- chg is registered, exactly one cycle per commit event. A joint commit yields a single pulse.
- stable is registered and derived from next-state counters: it drops the edge after the first mismatch and rises the edge a commit completes or a bounce clears.
- i1/i2 change only on commit edges, never combinationally.

Decomposition:
- Shared package fsm_in_pkg holds:
  - Default constants DB_CYCLES_DEF=8, SYNC_STAGES_DEF=2, SKEW_MAX_DEF=4.
  - A localparam function for counter width (clog2).
- One natural sub-module: fsm_in_db_chan, containing the synchroniser, debounce counter and READY/PENDING flags, instantiated twice.
- The top level owns the alignment/commit logic, wcnt, i1/i2, chg and stable.

Test Plan:
- Reset: drive nrst=0 with raw1=raw2=1, release → i1=i2=0, chg=0, stable=1; i1 rises exactly at edge 10 after release, with a single chg pulse.
- Clean single change: raw1 0→1, held, raw2=0 → i1=1 at edge 10, i2 stays 0, one chg pulse, stable low during edges 3..10.
- Bounce: raw1 0→1 for 5 cycles, back to 0 for 2, then 1 steady → no commit from the first burst; i1=1 only 10 edges after the final rise.
- Skew aligned: raw1 rises, raw2 rises 3 cycles later (SKEW_MAX=4) → i1 and i2 rise on the same edge (13 after raw1), single chg pulse; the combination i1=1,i2=0 is never output.
- Skew exceeded: raw2 rises 6 cycles after raw1 → i1 rises alone at edge 14 (10+SKEW_MAX), i2 rises at edge 16, two chg pulses.
- Reset mid-debounce: raw1 rises, nrst asserted at edge 6, released at edge 8 → i1=0 immediately; i1 rises 10 edges after release, since the synchroniser refills from the steady raw1.
